seq_approx_divider: RTL
=======================

SEQ_APPROX_DIVIDER -- requirements
Module: seq_approx_divider

Interface
REQ-001 SHALL have parameter W, default 8: divisor, quotient and remainder width; dividend is 2*W bits; legal range 4..32.
REQ-002 SHALL have parameter APPROX_ROWS, default 2: number of least-significant quotient iterations that use approximate subtractor cells; legal range 0..W.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request a division; accepted only when ready=1.
REQ-006 SHALL have port n, input, 2*W bits: dividend, sampled on accept.
REQ-007 SHALL have port d, input, W bits: divisor, sampled on accept.
REQ-008 SHALL have port ready, output, 1 bit: high in IDLE and DONE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when q and r become valid.
REQ-010 SHALL have port q, output, W bits: quotient.
REQ-011 SHALL have port r, output, W bits: remainder.
REQ-012 SHALL have port ovf, output, 1 bit: set when n[2W-1:W] >= d and d != 0.
REQ-013 SHALL have port dbz, output, 1 bit: set when d == 0.

Function
REQ-014 SHALL implement the FSM states IDLE, BUSY and DONE; the transitions are IDLE/DONE -> BUSY on start, BUSY -> DONE after iteration 0, and DONE -> IDLE when start=0.
REQ-015 SHALL, on accept, latch n and d, load the W-bit partial remainder R with n[2W-1:W], set iteration index i=W-1, and compute ovf/dbz from the latched operands.
REQ-016 SHALL, in each BUSY cycle, form P={R,n[i]} (W+1 bits), subtract d from P[W-1:0] through a W-cell ripple borrow chain with borrow-in 0, set q[i]=P[W]|~borrow_out, set R=q[i]?diff:P[W-1:0], and decrement i.
REQ-017 SHALL use exact cells when i >= APPROX_ROWS; an exact cell computes diff=x^y^bin and bout=(~x&y)|(~(x^y)&bin).
REQ-018 SHALL use approximate cells in all W columns when i < APPROX_ROWS; indexing (x,y,bin) as 3-bit codes, bout=1 exactly for codes 000,100,101,110 and diff=1 exactly for codes 000,101,110,111.
REQ-019 SHALL have a latency of exactly W BUSY cycles; done pulses in the cycle after iteration 0 (W+1 cycles after the accept edge), and r equals the final R at that point.
REQ-020 SHALL hold q, r, ovf and dbz stable from done until the next accept.
REQ-021 SHALL ignore start while in BUSY; start in DONE is accepted immediately (back-to-back).
REQ-022 SHALL, when d=0, follow the REQ-016 datapath unchanged: exact rows give q all-ones and r=n[W-1:0].
REQ-023 SHALL, when ovf=1, leave q and r as produced by the datapath; these values are architecturally undefined.

Reset
REQ-024 SHALL, on rst=1 at any clock edge (including mid-BUSY), go to IDLE with q=0, r=0, ovf=0, dbz=0, done=0 and ready=1, discarding any operation in flight.

Structure
REQ-025 SHALL place the FSM state typedef and the cell-mode enum (EXACT, APPROX) in the shared package seq_approx_div_pkg.
REQ-026 SHALL implement a single sub-module approx_sub_cell with a mode input selecting the exact or approximate truth table, instantiated W times for the one-row datapath.
REQ-027 SHALL not unroll the datapath across rows; area is one row plus control.

Verification
REQ-028 SHALL cover: W=8, APPROX_ROWS=0, n=1000, d=7 -> done after 8 BUSY cycles, q=142, r=6, ovf=0, dbz=0.
REQ-029 SHALL cover: W=8, n=16'h1234, d=0 -> dbz=1, q=8'hFF, r=8'h34.
REQ-030 SHALL cover: W=8, n=16'h0900, d=8 -> ovf=1, dbz=0 (q and r not checked).
REQ-031 SHALL cover: rst=1 in the 4th BUSY cycle -> next cycle IDLE with ready=1 and all outputs 0; a following start with n=1000, d=7 -> q=142, r=6.
REQ-032 SHALL cover: W=8, APPROX_ROWS=2, 10000 random operands plus start held high (back-to-back) -> every result bit-exact against a per-cell reference model of REQ-016..018, with no accept while BUSY.

Source files
------------

// File: rtl/seq_approx_div_pkg.sv
// Shared types for the sequential restoring divider with approximate low-order rows.
// Holds the controller state encoding, the subtractor cell mode and the row-mode rule.
package seq_approx_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    EXACT  = 1'b0,
    APPROX = 1'b1
  } cell_mode_e;

  // Quotient bits below approx_rows are produced by approximate cells.
  function automatic cell_mode_e row_mode(input int unsigned row, input int unsigned approx_rows);
    return (row < approx_rows) ? APPROX : EXACT;
  endfunction

endpackage

// File: rtl/approx_sub_cell.sv
// One-bit borrow subtractor cell computing x - y - bin.
// The mode input selects the exact full subtractor or the approximate truth table.
module approx_sub_cell
  import seq_approx_div_pkg::*;
(
  input  cell_mode_e mode_i,
  input  logic       x_i,
  input  logic       y_i,
  input  logic       bin_i,
  output logic       diff_o,
  output logic       bout_o
);

  logic [2:0] code;

  assign code = {x_i, y_i, bin_i};

  // NOTE: both outputs get a value before any branch so no path leaves them unassigned (no latch).
  always_comb begin
    diff_o = x_i ^ y_i ^ bin_i;
    bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);
    if (mode_i == APPROX) begin
      case (code)
        3'b000:  {diff_o, bout_o} = 2'b11;
        3'b001:  {diff_o, bout_o} = 2'b00;
        3'b010:  {diff_o, bout_o} = 2'b00;
        3'b011:  {diff_o, bout_o} = 2'b00;
        3'b100:  {diff_o, bout_o} = 2'b01;
        3'b101:  {diff_o, bout_o} = 2'b11;
        3'b110:  {diff_o, bout_o} = 2'b11;
        default: {diff_o, bout_o} = 2'b10;
      endcase
    end
  end

endmodule

// File: rtl/seq_approx_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, 2W/W -> W quotient and remainder.
// A single W-cell subtractor row is reused every cycle; low-order rows switch to approximate cells.
module seq_approx_divider
  import seq_approx_div_pkg::*;
#(
  parameter int W           = 8,
  parameter int APPROX_ROWS = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] n,
  input  logic [W-1:0]   d,
  output logic           ready,
  output logic           done,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           ovf,
  output logic           dbz
);

  localparam int IW = $clog2(W);
  localparam logic [IW:0] APPROX_LIM = (IW + 1)'(APPROX_ROWS);

  state_e        state_q;
  logic [W-1:0]  nlo_q;
  logic [W-1:0]  d_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  quo_q;
  logic [IW-1:0] idx_q;
  logic          ovf_q;
  logic          dbz_q;
  logic          done_q;
  logic          ready_q;

  // One row of the division array: trial subtraction of the divisor from the shifted remainder.
  logic [W:0]    p;
  logic [W:0]    borrow;
  logic [W-1:0]  diff;
  logic          qbit;
  logic [W-1:0]  rem_d;
  cell_mode_e    cell_mode;

  assign p         = {rem_q, nlo_q[idx_q]};
  assign borrow[0] = 1'b0;
  assign cell_mode = ({1'b0, idx_q} < APPROX_LIM) ? APPROX : EXACT;

  for (genvar k = 0; k < W; k++) begin : g_row
    approx_sub_cell u_cell (
      .mode_i (cell_mode),
      .x_i    (p[k]),
      .y_i    (d_q[k]),
      .bin_i  (borrow[k]),
      .diff_o (diff[k]),
      .bout_o (borrow[k+1])
    );
  end

  // A set carry-out bit of P means P >= 2^W > d, so the subtraction always succeeds.
  assign qbit  = p[W] | ~borrow[W];
  assign rem_d = qbit ? diff : p[W-1:0];

  // NOTE: every register here uses non-blocking assignment so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      nlo_q   <= '0;
      d_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            nlo_q   <= n[W-1:0];
            d_q     <= d;
            rem_q   <= n[2*W-1:W];
            idx_q   <= IW'(W - 1);
            ovf_q   <= (n[2*W-1:W] >= d) && (d != '0);
            dbz_q   <= (d == '0);
            ready_q <= 1'b0;
            state_q <= BUSY;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          quo_q[idx_q] <= qbit;
          rem_q        <= rem_d;
          if (idx_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign q     = quo_q;
  assign r     = rem_q;
  assign ovf   = ovf_q;
  assign dbz   = dbz_q;

endmodule
